// File: rtl/i2s_tx_sched.sv
// Stereo frame FIFO feeding an I2S transmitter, with an IDLE/PRIME/RUN scheduler.
// Latency: a frame popped on a left-slot boundary appears on left_chan/right_chan one edge later.
// Backpressure: in_ready = not full, and it is low in IDLE; it depends only on registered state.
module i2s_tx_sched #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int PRIME_LVL = 2
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cnt_clr,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_left,
    input  logic [DATA_W-1:0]       in_right,
    output logic                    in_ready,
    input  logic                    lrclk,
    output logic [DATA_W-1:0]       left_chan,
    output logic [DATA_W-1:0]       right_chan,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    running,
    output logic [15:0]             underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]        state;
    logic              lrclk_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem_l [DEPTH];
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [15:0]       cnt_nxt;

    logic boundary, full, empty, push, pop, underrun;

    assign boundary = lrclk_d & ~lrclk;
    assign full     = (fifo_level == LW'(DEPTH));
    assign empty    = (fifo_level == '0);
    assign in_ready = (state != ST_IDLE) & ~full;
    assign push     = in_valid & in_ready;
    // Boundary events are ignored while en is low so a disable never counts as an underrun.
    assign pop      = en & (state == ST_RUN) & boundary & ~empty;
    assign underrun = en & (state == ST_RUN) & boundary & empty;
    assign running  = (state == ST_RUN);

    always_comb begin
        cnt_nxt = underrun_cnt;
        if (cnt_clr)
            cnt_nxt = '0;
        else if (underrun && underrun_cnt != 16'hFFFF)
            cnt_nxt = underrun_cnt + 16'd1;
    end

    always_ff @(posedge sclk) begin
        if (push) begin
            mem_l[wr_ptr] <= in_left;
            mem_r[wr_ptr] <= in_right;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            lrclk_d      <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            left_chan    <= '0;
            right_chan   <= '0;
            underrun_cnt <= '0;
        end else begin
            lrclk_d      <= lrclk;
            underrun_cnt <= cnt_nxt;

            if (!en || state == ST_IDLE) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + LW'(1);
                    2'b01:   fifo_level <= fifo_level - LW'(1);
                    default: fifo_level <= fifo_level;
                endcase
            end

            if (!en || state == ST_IDLE) begin
                left_chan  <= '0;
                right_chan <= '0;
            end else if (pop) begin
                left_chan  <= mem_l[rd_ptr];
                right_chan <= mem_r[rd_ptr];
            end else if (underrun) begin
                left_chan  <= '0;
                right_chan <= '0;
            end

            if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_PRIME;
                    ST_PRIME: if (fifo_level >= LW'(PRIME_LVL)) state <= ST_RUN;
                    ST_RUN:   if (underrun) state <= ST_PRIME;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Directed bench for i2s_tx_sched: priming, back-pressure, underrun, saturation, disable, reset.
module tb_i2s_tx_sched;

    logic        sclk = 1'b0;
    logic        rst;
    logic        en;
    logic        cnt_clr;
    logic        in_valid;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic        in_ready;
    logic        lrclk;
    logic [31:0] left_chan;
    logic [31:0] right_chan;
    logic [2:0]  fifo_level;
    logic        running;
    logic [15:0] underrun_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    i2s_tx_sched #(.DATA_W(32), .DEPTH(4), .PRIME_LVL(2)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .en           (en),
        .cnt_clr      (cnt_clr),
        .in_valid     (in_valid),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_ready     (in_ready),
        .lrclk        (lrclk),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .fifo_level   (fifo_level),
        .running      (running),
        .underrun_cnt (underrun_cnt)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // lrclk falls for one cycle: the pop/underrun lands on the first edge.
    task automatic bnd();
        lrclk = 1'b0;
        tick();
        lrclk = 1'b1;
        tick();
    endtask

    task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        tick();
        in_valid = 1'b0;
    endtask

    // Starts in PRIME with an empty FIFO; ends in PRIME after one underrun.
    task automatic do_underrun(input logic clr, input logic push_at, input logic [15:0] exp_cnt,
                               input logic [2:0] exp_lvl);
        push_frame(32'd7, 32'd8);
        push_frame(32'd9, 32'd10);
        tick();
        chk("ur_running", {31'b0, running}, 32'd1);
        bnd();
        bnd();
        chk("ur_last_pop", left_chan, 32'd9);
        lrclk    = 1'b0;
        cnt_clr  = clr;
        in_valid = push_at;
        in_left  = 32'd55;
        in_right = 32'd66;
        tick();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        lrclk    = 1'b1;
        chk("ur_cnt", {16'b0, underrun_cnt}, {16'b0, exp_cnt});
        chk("ur_left_zero", left_chan, 32'd0);
        chk("ur_right_zero", right_chan, 32'd0);
        chk("ur_not_running", {31'b0, running}, 32'd0);
        chk("ur_level", {29'b0, fifo_level}, {29'b0, exp_lvl});
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
        in_left = '0; in_right = '0; lrclk = 1'b1;
        tick();
        tick();
        chk("rst_left", left_chan, 32'd0);
        chk("rst_right", right_chan, 32'd0);
        chk("rst_level", {29'b0, fifo_level}, 32'd0);
        chk("rst_running", {31'b0, running}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_cnt", {16'b0, underrun_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", {31'b0, in_ready}, 32'd0);

        // priming
        en = 1'b1;
        tick();
        chk("prime_in_ready", {31'b0, in_ready}, 32'd1);
        push_frame(32'd1, 32'd2);
        chk("prime_lvl1", {29'b0, fifo_level}, 32'd1);
        chk("prime_run_lvl1", {31'b0, running}, 32'd0);
        push_frame(32'd3, 32'd4);
        chk("prime_lvl2", {29'b0, fifo_level}, 32'd2);
        chk("prime_run_lvl2", {31'b0, running}, 32'd0);
        tick();
        chk("run_rise", {31'b0, running}, 32'd1);
        chk("run_out_before_pop", left_chan, 32'd0);
        bnd();
        chk("pop_a_left", left_chan, 32'd1);
        chk("pop_a_right", right_chan, 32'd2);
        chk("pop_a_level", {29'b0, fifo_level}, 32'd1);
        tick();
        chk("hold_a_left", left_chan, 32'd1);
        bnd();
        chk("pop_b_left", left_chan, 32'd3);
        chk("pop_b_right", right_chan, 32'd4);

        // underrun on the next boundary with nothing pushed
        lrclk = 1'b0;
        tick();
        lrclk = 1'b1;
        chk("under_left", left_chan, 32'd0);
        chk("under_right", right_chan, 32'd0);
        chk("under_cnt", {16'b0, underrun_cnt}, 32'd1);
        chk("under_running", {31'b0, running}, 32'd0);
        chk("under_in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // full back-pressure: five offers, no boundary
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_left  = 32'(k * 10);
            in_right = 32'(k * 10 + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("full_level", {29'b0, fifo_level}, 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_running", {31'b0, running}, 32'd1);
        lrclk = 1'b0;
        tick();
        lrclk = 1'b1;
        chk("full_pop_left", left_chan, 32'd10);
        chk("full_pop_right", right_chan, 32'd11);
        chk("full_pop_level", {29'b0, fifo_level}, 32'd3);
        chk("full_ready_back", {31'b0, in_ready}, 32'd1);
        tick();

        // disable in RUN with three frames held
        chk("dis_pre_level", {29'b0, fifo_level}, 32'd3);
        en = 1'b0;
        tick();
        chk("dis_level", {29'b0, fifo_level}, 32'd0);
        chk("dis_left", left_chan, 32'd0);
        chk("dis_right", right_chan, 32'd0);
        chk("dis_running", {31'b0, running}, 32'd0);
        chk("dis_in_ready", {31'b0, in_ready}, 32'd0);
        chk("dis_cnt", {16'b0, underrun_cnt}, 32'd1);

        // saturation: preload close to the top, then let real underruns finish the climb
        en = 1'b1;
        tick();
        force dut.underrun_cnt = 16'hFFFD;
        tick();
        release dut.underrun_cnt;
        do_underrun(1'b0, 1'b0, 16'hFFFE, 3'd0);
        do_underrun(1'b0, 1'b0, 16'hFFFF, 3'd0);
        do_underrun(1'b0, 1'b0, 16'hFFFF, 3'd0);
        // clear beats the increment; the frame offered on the underrun edge is stored
        do_underrun(1'b1, 1'b1, 16'h0000, 3'd1);

        // resume, pop the stored frame, then reset mid-operation
        push_frame(32'd77, 32'd88);
        tick();
        chk("resume_running", {31'b0, running}, 32'd1);
        bnd();
        chk("resume_pop_left", left_chan, 32'd55);
        chk("resume_pop_right", right_chan, 32'd66);
        chk("resume_level", {29'b0, fifo_level}, 32'd1);

        lrclk    = 1'b0;
        in_valid = 1'b1;
        in_left  = 32'd99;
        in_right = 32'd98;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_left", left_chan, 32'd0);
        chk("arst_right", right_chan, 32'd0);
        chk("arst_level", {29'b0, fifo_level}, 32'd0);
        chk("arst_running", {31'b0, running}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_left", left_chan, 32'd0);
        chk("post_rst_level", {29'b0, fifo_level}, 32'd0);
        chk("post_rst_running", {31'b0, running}, 32'd0);
        in_valid = 1'b0;
        lrclk    = 1'b1;
        chk("post_rst_prime", {31'b0, in_ready}, 32'd1);
        tick();
        chk("post_rst_hold_level", {29'b0, fifo_level}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
